// File: rtl/sdram_capture_writer.sv
`timescale 1ns/1ps
// sdram_capture_writer
// Drains a show-ahead capture FIFO of 256-bit words into an SDRAM buffer over
// the HPS f2h_sdram0 Avalon-MM port as write bursts. It tracks the write
// pointer and reports busy/done/full to the control registers.
// Optional feature macro: SDRAM_CAPTURE_RING_EN
//   defined     : ring buffer. The pointer wraps at the buffer end, full is sticky,
//                 and the capture ends only after stop and a FIFO flush.
//   not defined : linear buffer. The capture finishes as soon as the buffer is full.
//
// state   | meaning
// S_IDLE  | after reset, waiting for start
// S_PLAN  | pick the next burst length, wait for data, or finish
// S_BURST | avm_write held high, one FIFO word per accepted beat
// S_FIN   | capture complete, done high, waiting for the next start
module sdram_capture_writer #(
   parameter int ADDR_W    = 27,
   parameter int DATA_W    = 256,
   parameter int BURST_W   = 8,
   parameter int MAX_BURST = 16,
   parameter int LEVEL_W   = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     cfg_base,
   input  logic [ADDR_W-1:0]     cfg_words,
   input  logic                  start,
   input  logic                  stop,
   output logic                  busy,
   output logic                  done,
   output logic                  full,
   output logic [ADDR_W-1:0]     wr_ptr,
   input  logic [DATA_W-1:0]     fifo_rdata,
   input  logic [LEVEL_W-1:0]    fifo_level,
   output logic                  fifo_rd,
   output logic [ADDR_W-1:0]     avm_address,
   output logic [BURST_W-1:0]    avm_burstcount,
   output logic                  avm_write,
   output logic [DATA_W-1:0]     avm_writedata,
   output logic [DATA_W/8-1:0]   avm_byteenable,
   input  logic                  avm_waitrequest
);

   // One bit of headroom so that the level, the remaining space and the
   // burst limit compare without truncation.
   localparam int CW = ((ADDR_W > LEVEL_W) ? ADDR_W : LEVEL_W) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAN,
      S_BURST,
      S_FIN
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   base_r;
   logic [ADDR_W-1:0]   words_r;
   logic                stop_pending;
   logic [BURST_W-1:0]  beats_left;

   logic [CW-1:0]       remaining;
   logic [CW-1:0]       level_x;
   logic [CW-1:0]       max_x;
   logic [CW-1:0]       len;
   logic                issue;
   logic                beat;
   logic [ADDR_W-1:0]   next_ptr;

   // Burst planning. The tail rule waits until the whole remainder of the
   // buffer is in the FIFO, so the last burst before the end is never split.
   always_comb begin
      remaining = CW'(words_r - wr_ptr);
      level_x   = CW'(fifo_level);
      max_x     = CW'(MAX_BURST);
      len       = max_x;
      if (level_x < len) begin
         len = level_x;
      end
      if (remaining < len) begin
         len = remaining;
      end
      issue = (len != '0) &&
              ((level_x >= max_x) ||
               stop_pending ||
               ((remaining < max_x) && (level_x >= remaining)));
   end

   assign beat           = avm_write & ~avm_waitrequest;
   assign fifo_rd        = beat;
   assign avm_writedata  = fifo_rdata;
   assign avm_byteenable = '1;
   assign next_ptr       = wr_ptr + ADDR_W'(avm_burstcount);

   // Control FSM: latches the configuration, runs the bursts and advances the write pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         base_r         <= '0;
         words_r        <= '0;
         wr_ptr         <= '0;
         full           <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         stop_pending   <= 1'b0;
         avm_address    <= '0;
         avm_burstcount <= BURST_W'(1);
         avm_write      <= 1'b0;
         beats_left     <= '0;
      end else begin
         case (state)
            S_IDLE, S_FIN: begin
               if (start) begin
                  base_r       <= cfg_base;
                  words_r      <= cfg_words;
                  wr_ptr       <= '0;
                  stop_pending <= 1'b0;
                  if (cfg_words == '0) begin
                     full  <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     full  <= 1'b0;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                     state <= S_PLAN;
                  end
               end
            end
            S_PLAN: begin
               if (stop) begin
                  stop_pending <= 1'b1;
               end
               if (issue) begin
                  avm_address    <= base_r + wr_ptr;
                  avm_burstcount <= BURST_W'(len);
                  beats_left     <= BURST_W'(len);
                  avm_write      <= 1'b1;
                  state          <= S_BURST;
               end else if (stop_pending && (fifo_level == '0)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_FIN;
               end
            end
            S_BURST: begin
               if (stop) begin
                  stop_pending <= 1'b1;
               end
               if (beat) begin
                  beats_left <= beats_left - BURST_W'(1);
                  if (beats_left == BURST_W'(1)) begin
                     avm_write <= 1'b0;
                     if (next_ptr == words_r) begin
                        full <= 1'b1;
`ifdef SDRAM_CAPTURE_RING_EN
                        wr_ptr <= '0;
                        state  <= S_PLAN;
`else
                        wr_ptr <= next_ptr;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_FIN;
`endif
                     end else begin
                        wr_ptr <= next_ptr;
                        state  <= S_PLAN;
                     end
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_capture_writer.sv
`timescale 1ns/1ps
// tb_sdram_capture_writer
// Directed and randomized bursts against a queue-based FIFO and a burst-list
// reference model. Set SDRAM_CAPTURE_RING_EN to match the design build.
module tb_sdram_capture_writer;
   localparam int ADDR_W    = 27;
   localparam int DATA_W    = 256;
   localparam int BURST_W   = 8;
   localparam int MAX_BURST = 16;
   localparam int LEVEL_W   = 10;
`ifdef SDRAM_CAPTURE_RING_EN
   localparam bit RING = 1'b1;
`else
   localparam bit RING = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [ADDR_W-1:0]     cfg_base = '0;
   logic [ADDR_W-1:0]     cfg_words = '0;
   logic                  start = 1'b0;
   logic                  stop = 1'b0;
   logic                  busy, done, full;
   logic [ADDR_W-1:0]     wr_ptr;
   logic [DATA_W-1:0]     fifo_rdata = '0;
   logic [LEVEL_W-1:0]    fifo_level = '0;
   logic                  fifo_rd;
   logic [ADDR_W-1:0]     avm_address;
   logic [BURST_W-1:0]    avm_burstcount;
   logic                  avm_write;
   logic [DATA_W-1:0]     avm_writedata;
   logic [DATA_W/8-1:0]   avm_byteenable;
   logic                  avm_waitrequest = 1'b0;

   always #5 clk = ~clk;

   sdram_capture_writer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
      .MAX_BURST(MAX_BURST), .LEVEL_W(LEVEL_W)
   ) dut (
      .clk(clk), .reset(reset),
      .cfg_base(cfg_base), .cfg_words(cfg_words),
      .start(start), .stop(stop),
      .busy(busy), .done(done), .full(full), .wr_ptr(wr_ptr),
      .fifo_rdata(fifo_rdata), .fifo_level(fifo_level), .fifo_rd(fifo_rd),
      .avm_address(avm_address), .avm_burstcount(avm_burstcount),
      .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest)
   );

   int total = 0;
   int bad   = 0;

   // FIFO model: the main sequence only bumps pushed_total / flush_gen.
   logic [DATA_W-1:0] fifo_q[$];
   int  pushed_total = 0;
   int  flush_gen    = 0;
   logic pop_s       = 1'b0;
   bit  stall_en     = 1'b0;

   // Beat log kept by the monitor.
   logic [ADDR_W-1:0] log_addr[$];
   int                log_len[$];
   logic [DATA_W-1:0] log_data[$];
   int                write_cycles = 0;

   // Expected bursts from the reference model.
   logic [ADDR_W-1:0] exp_addr[$];
   int                exp_len[$];
   int                exp_ptr;
   int                exp_left;
   bit                exp_full;

   function automatic logic [DATA_W-1:0] word_of(input int k);
      logic [DATA_W-1:0] w;
      for (int i = 0; i < DATA_W/32; i++) begin
         w[i*32 +: 32] = 32'(k) * 32'h9E37_79B1 + 32'(i);
      end
      return w;
   endfunction

   initial begin : fifo_model
      int loaded;
      int flush_seen;
      logic [DATA_W-1:0] junk;
      loaded = 0;
      flush_seen = 0;
      forever begin
         @(posedge clk);
         if (flush_gen != flush_seen) begin
            fifo_q.delete();
            loaded = pushed_total;
            flush_seen = flush_gen;
         end else begin
            if (pop_s && fifo_q.size() > 0) begin
               junk = fifo_q.pop_front();
            end
            while (loaded < pushed_total) begin
               fifo_q.push_back(word_of(loaded));
               loaded++;
            end
         end
         fifo_level <= LEVEL_W'(fifo_q.size());
         fifo_rdata <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         pop_s = fifo_rd;
         if (fifo_rd) begin
            log_addr.push_back(avm_address);
            log_len.push_back(int'(avm_burstcount));
            log_data.push_back(avm_writedata);
         end
         if (avm_write) begin
            write_cycles++;
         end
      end
   end

   initial begin : stall_driver
      forever begin
         @(posedge clk);
         #1;
         avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Burst list from the capture rules, assuming the FIFO contents are fixed before start.
   task automatic build_model(input logic [ADDR_W-1:0] b, input int w, input int n, input bit stp);
      int ptr, used, rem, av, len;
      ptr = 0;
      used = 0;
      exp_addr.delete();
      exp_len.delete();
      exp_full = (w == 0);
      while (w != 0) begin
         rem = w - ptr;
         av  = n - used;
         len = MAX_BURST;
         if (av < len) len = av;
         if (rem < len) len = rem;
         if (len == 0) break;
         if (!(av >= MAX_BURST || stp || (rem < MAX_BURST && av >= rem))) break;
         exp_addr.push_back(b + ADDR_W'(ptr));
         exp_len.push_back(len);
         ptr += len;
         used += len;
         if (ptr == w) begin
            exp_full = 1'b1;
            if (RING) ptr = 0;
            else break;
         end
      end
      exp_ptr  = ptr;
      exp_left = n - used;
   endtask

   task automatic prep_fifo(input int n, output int k0);
      flush_gen++;
      tick();
      k0 = pushed_total;
      pushed_total += n;
      tick();
      tick();
   endtask

   task automatic wait_done(input string tag);
      int t;
      t = 0;
      while (done !== 1'b1 && t < 3000) begin
         tick();
         t++;
      end
      chk({tag, "_done"}, 64'(done), 64'(1));
   endtask

   task automatic check_beats(input string tag, input int lo, input int k0);
      int nb, j;
      nb = 0;
      foreach (exp_len[i]) nb += exp_len[i];
      chk({tag, "_beats"}, 64'(log_data.size() - lo), 64'(nb));
      j = lo;
      foreach (exp_len[i]) begin
         for (int m = 0; m < exp_len[i]; m++) begin
            if (j < log_data.size()) begin
               total++;
               assert (log_addr[j] === exp_addr[i] && log_len[j] === exp_len[i] &&
                       log_data[j] === word_of(k0 + j - lo)) else begin
                  bad++;
                  $error("FAIL %s_beat%0d: observed addr=%0h len=%0d data=%0h expected addr=%0h len=%0d data=%0h",
                         tag, j - lo, log_addr[j], log_len[j], log_data[j][31:0],
                         exp_addr[i], exp_len[i], word_of(k0 + j - lo) & 256'hFFFF_FFFF);
               end
            end
            j++;
         end
      end
   endtask

   task automatic run_case(input string tag, input logic [ADDR_W-1:0] b, input int w,
                           input int n, input bit stp, input bit stall);
      int lo, k0, wc0;
      bit exp_first;
      prep_fifo(n, k0);
      build_model(b, w, n, stp);
      lo  = log_data.size();
      wc0 = write_cycles;
      cfg_base  = b;
      cfg_words = ADDR_W'(w);
      stall_en  = stall;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'(w != 0));
      exp_first = (w != 0) && (n >= MAX_BURST || (w < MAX_BURST && n >= w));
      if (stp) stop = 1'b1;
      tick();
      stop = 1'b0;
      chk({tag, "_first_wr"}, 64'(avm_write), 64'(exp_first));
      wait_done(tag);
      stall_en = 1'b0;
      tick();
      chk({tag, "_busy_end"}, 64'(busy), 64'(0));
      chk({tag, "_wr_ptr"}, 64'(wr_ptr), 64'(exp_ptr));
      chk({tag, "_full"}, 64'(full), 64'(exp_full));
      chk({tag, "_left"}, 64'(fifo_level), 64'(exp_left));
      if (exp_len.size() == 0) begin
         chk({tag, "_no_write"}, 64'(write_cycles - wc0), 64'(0));
      end
      check_beats(tag, lo, k0);
   endtask

   initial begin : main
      int k0, lo, t, wc0;
      logic [ADDR_W-1:0] b;

      repeat (3) tick();
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_full", 64'(full), 64'(0));
      chk("rst_write", 64'(avm_write), 64'(0));
      chk("rst_fifo_rd", 64'(fifo_rd), 64'(0));
      chk("rst_wr_ptr", 64'(wr_ptr), 64'(0));
      chk("rst_addr", 64'(avm_address), 64'(0));
      chk("rst_bc", 64'(avm_burstcount), 64'(1));
      reset = 1'b0;
      tick();
      chk("byteenable", 64'(&avm_byteenable), 64'(1));

      // stop while idle does nothing
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      chk("idle_stop_busy", 64'(busy), 64'(0));
      chk("idle_stop_done", 64'(done), 64'(0));

      run_case("basic64", ADDR_W'(32'h100), 64, 64, RING, 1'b0);
      run_case("lvl5", ADDR_W'(32'h4000), 64, 5, 1'b1, 1'b0);
      run_case("stall16", ADDR_W'($urandom), 100, 16, 1'b1, 1'b1);
      run_case("w40", ADDR_W'(32'h800), 40, 48, RING, 1'b0);

      // asynchronous reset in the middle of a burst
      prep_fifo(16, k0);
      lo = log_data.size();
      cfg_base  = ADDR_W'(32'h2000);
      cfg_words = ADDR_W'(64);
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
      while (log_data.size() - lo < 7 && t < 200) begin
         tick();
         t++;
      end
      chk("mid_beats", 64'(log_data.size() - lo), 64'(7));
      chk("mid_write", 64'(avm_write), 64'(1));
      reset = 1'b1;
      #1;
      chk("arst_write", 64'(avm_write), 64'(0));
      chk("arst_fifo_rd", 64'(fifo_rd), 64'(0));
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_wr_ptr", 64'(wr_ptr), 64'(0));
      tick();
      tick();
      reset = 1'b0;
      tick();
      run_case("post_rst", ADDR_W'(32'h3000), 20, 20, RING, 1'b0);

      // start while busy is ignored: base and length stay as first latched
      prep_fifo(3, k0);
      build_model(ADDR_W'(32'h5000), 50, 3, 1'b1);
      lo  = log_data.size();
      wc0 = write_cycles;
      cfg_base  = ADDR_W'(32'h5000);
      cfg_words = ADDR_W'(50);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("wait_busy", 64'(busy), 64'(1));
      chk("wait_no_write", 64'(write_cycles - wc0), 64'(0));
      cfg_base  = ADDR_W'(32'h7700);
      cfg_words = ADDR_W'(3);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("restart_ignored", 64'(write_cycles - wc0), 64'(0));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done("restart");
      tick();
      chk("restart_wr_ptr", 64'(wr_ptr), 64'(3));
      chk("restart_full", 64'(full), 64'(0));
      check_beats("restart", lo, k0);

      // stop after done does nothing
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      chk("fin_stop_done", 64'(done), 64'(1));
      chk("fin_stop_busy", 64'(busy), 64'(0));

      run_case("zero", ADDR_W'(32'h9000), 0, 5, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         b = ADDR_W'($urandom);
         if (i % 2 == 1) b = ADDR_W'((1 << ADDR_W) - int'($urandom_range(1, 40)));
         run_case($sformatf("rnd%0d", i), b, int'($urandom_range(1, 60)),
                  int'($urandom_range(0, 70)), 1'b1, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
